// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter: grants one cache, broadcasts its op, ORs the other caches' snoop results.
// Latency: grant 1 cycle after req sample, done 1 cycle after last ack; no backpressure, requests wait in IDLE.
module snoop_bus_arbiter #(
    parameter int NUM_CORES     = 4,
    parameter int ADDR_W        = 20,
    parameter int SNOOP_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [2*NUM_CORES-1:0]      req_op,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    output logic [NUM_CORES-1:0]        gnt,
    output logic                        bus_valid,
    output logic [1:0]                  bus_op,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [1:0]                  bus_src,
    input  logic [NUM_CORES-1:0]        snoop_ack,
    input  logic [NUM_CORES-1:0]        snoop_hit,
    input  logic [NUM_CORES-1:0]        snoop_dirty,
    output logic                        done,
    output logic                        shared,
    output logic                        wb_needed,
    output logic [1:0]                  dirty_src,
    output logic                        timeout_err
);
    localparam int IDX_W = 2;
    localparam int CNT_W = $clog2(SNOOP_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BCAST, COLLECT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [NUM_CORES-1:0]   ack_acc_q, ack_acc_d;
    logic [NUM_CORES-1:0]   hit_acc_q, hit_acc_d;
    logic [NUM_CORES-1:0]   dirty_acc_q, dirty_acc_d;
    logic [NUM_CORES-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CORES-1:0]   gnt_q, gnt_d;
    logic                   bus_valid_q, bus_valid_d;
    logic [1:0]             bus_op_q, bus_op_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [IDX_W-1:0]       bus_src_q, bus_src_d;
    logic                   done_q, done_d;
    logic                   shared_q, shared_d;
    logic                   wb_q, wb_d;
    logic [IDX_W-1:0]       dirty_src_q, dirty_src_d;
    logic                   tmo_q, tmo_d;

    logic                   found;
    logic [IDX_W-1:0]       sel, cand;
    logic [NUM_CORES-1:0]   ack_v, ack_all, hit_all, dirty_all;
    logic [IDX_W-1:0]       dsel;

    // Round-robin pick: first requester at or above the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // exp_q excludes the requester, so its own ack/hit/dirty never count.
    always_comb begin
        ack_v     = snoop_ack & exp_q;
        ack_all   = ack_acc_q | ack_v;
        hit_all   = hit_acc_q | (ack_v & snoop_hit);
        dirty_all = dirty_acc_q | (ack_v & snoop_dirty);
        dsel      = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (dirty_all[i]) dsel = IDX_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ack_acc_d   = ack_acc_q;
        hit_acc_d   = hit_acc_q;
        dirty_acc_d = dirty_acc_q;
        exp_d       = exp_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        bus_valid_d = 1'b0;
        bus_op_d    = bus_op_q;
        bus_addr_d  = bus_addr_q;
        bus_src_d   = bus_src_q;
        done_d      = 1'b0;
        shared_d    = 1'b0;
        wb_d        = 1'b0;
        dirty_src_d = '0;
        tmo_d       = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    gnt_d[sel]  = 1'b1;
                    bus_valid_d = 1'b1;
                    bus_op_d    = req_op[2*sel +: 2];
                    bus_addr_d  = req_addr[ADDR_W*sel +: ADDR_W];
                    bus_src_d   = sel;
                    state_d     = BCAST;
                end
            end
            BCAST: begin
                ack_acc_d   = '0;
                hit_acc_d   = '0;
                dirty_acc_d = '0;
                cnt_d       = '0;
                exp_d       = ~gnt_q;
                state_d     = COLLECT;
            end
            COLLECT: begin
                ack_acc_d   = ack_all;
                hit_acc_d   = hit_all;
                dirty_acc_d = dirty_all;
                cnt_d       = cnt_q + CNT_W'(1);
                if ((ack_all & exp_q) == exp_q || cnt_q == CNT_W'(SNOOP_TIMEOUT - 1)) begin
                    done_d      = 1'b1;
                    shared_d    = |hit_all;
                    wb_d        = |dirty_all;
                    dirty_src_d = dsel;
                    tmo_d       = (ack_all & exp_q) != exp_q;
                    state_d     = DONE;
                end
            end
            DONE: begin
                gnt_d   = '0;
                ptr_d   = bus_src_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            ack_acc_q   <= '0;
            hit_acc_q   <= '0;
            dirty_acc_q <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_op_q    <= '0;
            bus_addr_q  <= '0;
            bus_src_q   <= '0;
            done_q      <= 1'b0;
            shared_q    <= 1'b0;
            wb_q        <= 1'b0;
            dirty_src_q <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ack_acc_q   <= ack_acc_d;
            hit_acc_q   <= hit_acc_d;
            dirty_acc_q <= dirty_acc_d;
            exp_q       <= exp_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            bus_valid_q <= bus_valid_d;
            bus_op_q    <= bus_op_d;
            bus_addr_q  <= bus_addr_d;
            bus_src_q   <= bus_src_d;
            done_q      <= done_d;
            shared_q    <= shared_d;
            wb_q        <= wb_d;
            dirty_src_q <= dirty_src_d;
            tmo_q       <= tmo_d;
        end
    end

    assign gnt         = gnt_q;
    assign bus_valid   = bus_valid_q;
    assign bus_op      = bus_op_q;
    assign bus_addr    = bus_addr_q;
    assign bus_src     = bus_src_q;
    assign done        = done_q;
    assign shared      = shared_q;
    assign wb_needed   = wb_q;
    assign dirty_src   = dirty_src_q;
    assign timeout_err = tmo_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed stimulus for snoop_bus_arbiter; a negedge monitor pops expected broadcasts and completions from queues.
module tb_snoop_bus_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  req_op;
    logic [79:0] req_addr;
    logic [3:0]  gnt;
    logic        bus_valid;
    logic [1:0]  bus_op;
    logic [19:0] bus_addr;
    logic [1:0]  bus_src;
    logic [3:0]  snoop_ack, snoop_hit, snoop_dirty;
    logic        done, shared, wb_needed, timeout_err;
    logic [1:0]  dirty_src;

    snoop_bus_arbiter #(.NUM_CORES(4), .ADDR_W(20), .SNOOP_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
        .gnt(gnt), .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_src(bus_src), .snoop_ack(snoop_ack), .snoop_hit(snoop_hit),
        .snoop_dirty(snoop_dirty), .done(done), .shared(shared),
        .wb_needed(wb_needed), .dirty_src(dirty_src), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [3:0]  gnt;
        logic [1:0]  op;
        logic [19:0] addr;
        logic [1:0]  src;
        int          cyc;
    } bexp_t;
    typedef struct {
        logic [3:0] gnt;
        logic       sh;
        logic       wb;
        logic [1:0] ds;
        logic       tmo;
        int         cyc;
    } dexp_t;

    bexp_t bq[$];
    dexp_t dq[$];
    bexp_t mb;
    dexp_t md;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    k;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_bcast(input int c0, input logic [1:0] src, input logic [1:0] op, input logic [19:0] addr);
        bexp_t b;
        b.gnt = 4'b0001 << src; b.op = op; b.addr = addr; b.src = src; b.cyc = c0 + 1;
        bq.push_back(b);
    endtask

    task automatic exp_done(input int c, input logic [1:0] src, input logic sh, input logic wb,
                            input logic [1:0] ds, input logic tmo);
        dexp_t d;
        d.gnt = 4'b0001 << src; d.sh = sh; d.wb = wb; d.ds = ds; d.tmo = tmo; d.cyc = c;
        dq.push_back(d);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_bus_valid"}, bus_valid, 0);
        chk({tag, "_bus_op"}, bus_op, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_src"}, bus_src, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_shared"}, shared, 0);
        chk({tag, "_wb_needed"}, wb_needed, 0);
        chk({tag, "_dirty_src"}, dirty_src, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_valid) begin
                if (bq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_bus_valid: got src %0d addr 0x%0h required no broadcast (cycle %0d)", bus_src, bus_addr, cyc);
                end else begin
                    mb = bq.pop_front();
                    chk("bcast_cycle", cyc, mb.cyc);
                    chk("bcast_gnt", gnt, mb.gnt);
                    chk("bcast_op", bus_op, mb.op);
                    chk("bcast_addr", bus_addr, mb.addr);
                    chk("bcast_src", bus_src, mb.src);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: got done with src %0d required no completion (cycle %0d)", bus_src, cyc);
                end else begin
                    md = dq.pop_front();
                    chk("done_cycle", cyc, md.cyc);
                    chk("done_gnt", gnt, md.gnt);
                    chk("done_shared", shared, md.sh);
                    chk("done_wb_needed", wb_needed, md.wb);
                    chk("done_dirty_src", dirty_src, md.ds);
                    chk("done_timeout_err", timeout_err, md.tmo);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; req = '0; req_op = '0; req_addr = '0;
        snoop_ack = '0; snoop_hit = '0; snoop_dirty = '0;
        #1 rst = 1'b1;
        step(2);
        chk_all_zero("reset");
        rst = 1'b0;
        step(1);

        // Single request from core 1, others ack at once with no hits.
        k = cyc;
        req = 4'b0010; req_op[3:2] = 2'b00; req_addr[39:20] = 20'h1A2B4;
        exp_bcast(k, 2'd1, 2'b00, 20'h1A2B4);
        exp_done(k + 3, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        step(2);
        snoop_ack = 4'b1101; snoop_hit = 4'b0000;
        step(1);
        snoop_ack = '0; req = '0;
        step(1);
        chk("single_gnt_released", gnt, 0);
        chk("single_done_pulse", done, 0);
        step(1);

        // Requester's own responses, BCAST-cycle acks and dropped req must not matter.
        k = cyc;
        req = 4'b0100; req_op[5:4] = 2'b10; req_addr[59:40] = 20'h55555;
        exp_bcast(k, 2'd2, 2'b10, 20'h55555);
        exp_done(k + 4, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1);
        snoop_ack = 4'b1111; snoop_hit = 4'b1111; snoop_dirty = 4'b1111;
        step(1);
        req = '0; snoop_ack = 4'b0100; snoop_hit = 4'b0100; snoop_dirty = 4'b0100;
        step(1);
        snoop_ack = 4'b1011; snoop_hit = '0; snoop_dirty = '0;
        step(1);
        snoop_ack = '0;
        step(1);

        // Reset while core 2 is in COLLECT; pointer was 3 and must return to 0.
        k = cyc;
        req = 4'b0100; req_op[5:4] = 2'b01; req_addr[59:40] = 20'h0F0F0;
        exp_bcast(k, 2'd2, 2'b01, 20'h0F0F0);
        step(2);
        chk("pre_reset_gnt", gnt, 4'b0100);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        step(2);
        rst = 1'b0;
        k = cyc;
        req = 4'b1100; req_op[7:6] = 2'b11; req_addr[79:60] = 20'h33333;
        snoop_ack = 4'b1111; snoop_hit = 4'b1000; snoop_dirty = '0;
        exp_bcast(k, 2'd2, 2'b01, 20'h0F0F0);
        exp_done(k + 3, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0);
        exp_bcast(k + 4, 2'd3, 2'b11, 20'h33333);
        exp_done(k + 7, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0);
        step(5);
        req = '0;
        step(3);
        snoop_ack = '0; snoop_hit = '0;
        step(1);

        // Fairness: all four request continuously from pointer 0.
        k = cyc;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_op[2*i +: 2]    = 2'(i);
            req_addr[20*i +: 20] = 20'h10000 + 20'(i);
        end
        snoop_ack = 4'b1111; snoop_hit = 4'b0001; snoop_dirty = '0;
        for (int j = 0; j < 5; j++) begin
            exp_bcast(k + 4*j, 2'(j % 4), 2'(j % 4), 20'h10000 + 20'(j % 4));
            exp_done(k + 4*j + 3, 2'(j % 4), (j % 4) != 0, 1'b0, 2'd0, 1'b0);
        end
        step(17);
        req = '0;
        step(3);
        snoop_ack = '0; snoop_hit = '0;
        step(1);

        // Dirty snoop: core 2 holds M, completion waits for cores 1 and 3.
        k = cyc;
        req = 4'b0001; req_op[1:0] = 2'b01; req_addr[19:0] = 20'h0ABCD;
        exp_bcast(k, 2'd0, 2'b01, 20'h0ABCD);
        exp_done(k + 4, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0);
        step(2);
        snoop_ack = 4'b0101; snoop_hit = 4'b0101; snoop_dirty = 4'b0101;
        step(1);
        snoop_ack = 4'b1010; snoop_hit = 4'b1010; snoop_dirty = '0;
        step(1);
        snoop_ack = '0; snoop_hit = '0; req = '0;
        step(1);

        // Timeout: core 1 never acks; its unacked hit must not count.
        k = cyc;
        req = 4'b1000; req_op[7:6] = 2'b00; req_addr[79:60] = 20'h7FFFF;
        exp_bcast(k, 2'd3, 2'b00, 20'h7FFFF);
        exp_done(k + 17, 2'd3, 1'b1, 1'b0, 2'd0, 1'b1);
        step(2);
        snoop_ack = 4'b0101; snoop_hit = 4'b0110; snoop_dirty = '0;
        step(15);
        snoop_ack = '0; snoop_hit = '0; req = '0;
        step(3);

        chk("bcast_queue_drained", bq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Shares the single snoop bus between the four L1 data caches of the MESI subsystem.
- Grants the bus to one requesting cache at a time using round-robin priority.
- Broadcasts the winning coherence transaction to all caches and collects the snoop responses from every other cache.
- Returns the combined shared/dirty result to the requester, which uses it to choose its E/S fill state or M-line write-back.

Parameters:
NUM_CORES  4  number of caches/requesters; fixed at 4 for this release (2-bit indices)
ADDR_W  20  block address width, matching the cache data_addr
SNOOP_TIMEOUT  15  max COLLECT cycles before forced completion

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NUM_CORES  per-cache bus request; held high until done
req_op  input  2*NUM_CORES  per-cache op, slice [2i+1:2i]: 00 BusRd, 01 BusRdX, 10 BusUpgr, 11 reserved
req_addr  input  NUM_CORES*ADDR_W  per-cache block address, slice i
gnt  output  NUM_CORES  one-hot grant
bus_valid  output  1  snoop broadcast strobe, one cycle
bus_op  output  2  broadcast op
bus_addr  output  ADDR_W  broadcast address
bus_src  output  2  index of granted cache
snoop_ack  input  NUM_CORES  per-cache snoop response valid
snoop_hit  input  NUM_CORES  snooper holds the line (S/E/M); sampled with ack
snoop_dirty  input  NUM_CORES  snooper holds the line in M; sampled with ack
done  output  1  transaction complete, one-cycle pulse
shared  output  1  any other cache hit; valid with done
wb_needed  output  1  any other cache dirty; valid with done
dirty_src  output  2  lowest-index dirty snooper; valid with done
timeout_err  output  1  completion was forced by timeout; valid with done

Behaviour:
- Reset: state IDLE; round-robin pointer 0; ack/hit/dirty accumulators 0; timeout counter 0. All outputs 0 (gnt, bus_valid, bus_op, bus_addr, bus_src, done, shared, wb_needed, dirty_src, timeout_err). Reset asserted mid-transaction aborts it immediately. Nothing is replayed; the requester re-issues.
- FSM states: IDLE, BCAST, COLLECT, DONE. All outputs are registered.
- IDLE: when req != 0, pick the first set bit scanning from the pointer upward with wrap (order ptr, ptr+1, …, ptr+3 mod 4). Latch its index, op and addr, then go to BCAST. When req == 0, stay in IDLE.
- BCAST (1 cycle):
  - gnt = onehot(src); bus_valid = 1; bus_op, bus_addr and bus_src are driven from the latches.
  - Clear the accumulators. Set the expected-ack mask to all cores except src.
  - Next state: COLLECT.
- COLLECT:
  - gnt is held; bus_valid = 0; bus_op, bus_addr and bus_src stay stable.
  - Each cycle, OR snoop_ack into the ack accumulator. Also OR (ack & hit) into the hit accumulator and (ack & dirty) into the dirty accumulator.
  - The src bit of every input is ignored.
  - Acks arriving in BCAST are ignored; snoopers respond at the earliest in the first COLLECT cycle.
  - When (acc | current ack) covers the expected mask, go to DONE next cycle. Acks seen in that same cycle are included in the result.
  - Counter increments each COLLECT cycle. If the count reaches SNOOP_TIMEOUT with the mask incomplete, go to DONE with timeout_err = 1.
  - Repeated acks from the same core are harmless (OR).
- DONE (1 cycle):
  - done = 1; gnt still asserted.
  - shared = |hit_acc; wb_needed = |dirty_acc; dirty_src = lowest set index of dirty_acc (0 if none).
  - More than one dirty snooper is a protocol violation and is not separately flagged.
  - The pointer updates to (src+1) mod 4. Next state: IDLE.
  - In the following cycle, gnt, done, shared, wb_needed, dirty_src and timeout_err return to 0.
- Latency: with req sampled in cycle N and all acks arriving in N+2, the timeline is gnt/bus_valid in N+1, done in N+3, and the next arbitration in N+4. The minimum period is 4 cycles per transaction.
- Requests are not preempted. req deasserting after grant does not abort the transaction. req_op/req_addr changes after the IDLE sample are ignored.
- Op 11 is broadcast unchanged; its semantics are the snoopers' concern.
- Round-robin is applied only on grant, so a continuously requesting core waits at most 3 transactions.

Test Plan:
- Single request: req=0010, op=BusRd, addr=0x1A2B4; cores 0, 2 and 3 ack in the first COLLECT cycle with hit=0 → gnt=0010 for 3 cycles; bus_valid for 1 cycle with bus_addr=0x1A2B4, bus_src=1; done 3 cycles after the req sample with shared=0, wb_needed=0, timeout_err=0.
- Fairness: req=1111 held for 5 transactions starting from ptr=0 → bus_src sequence 0,1,2,3,0; each done is 4 cycles apart.
- Dirty snoop: core 0 issues BusRdX; core 2 acks with hit=1, dirty=1; cores 1 and 3 ack one cycle later with hit=1 → done has shared=1, wb_needed=1, dirty_src=2, and done waits for the last ack.
- Timeout: core 3 requests and core 1 never acks → done arrives after 15 COLLECT cycles with timeout_err=1; shared reflects only the acks from cores 0 and 2.
- Reset mid-COLLECT: assert rst while gnt=0100 → all outputs 0 asynchronously; after release, req=0100 is re-granted from ptr=0.
- Ignored inputs: requester ack/hit/dirty asserted while granted, and req dropped during COLLECT → neither affects shared, wb_needed or completion.
